// File: rtl/ahb_timer_if.sv
// AHB-Lite slave-side bus bundle for the timer: address/data phase inputs
// from the master plus the slave's ready, response and read data.
interface ahb_timer_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_timer.sv
// AHB-Lite down-counting timer: prescaled tick, periodic or one-shot reload,
// sticky TIMEOUT flag (W1C) and level interrupt. Zero-wait-state slave.
module ahb_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    ahb_timer_if.slave bus,
    output logic       irq
);
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_LOAD     = 3'd1;
    localparam logic [2:0] OFF_VALUE    = 3'd2;
    localparam logic [2:0] OFF_PRESCALE = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic                  dp_valid_reg, dp_write_reg;
    logic [2:0]            dp_addr_reg;
    logic                  en_reg, irq_en_reg, oneshot_reg, timeout_reg;
    logic                  en_next, irq_en_next, oneshot_next, timeout_next;
    logic [31:0]           load_reg, value_reg, load_next, value_next;
    logic [PRESCALE_W-1:0] prescale_reg, pcnt_reg, prescale_next, pcnt_next;
    logic [PRESCALE_W-1:0] pcnt_run;
    logic [31:0]           rdata;
    logic                  addr_phase, wr_en, tick, expire;
    logic [4:0]            wr_sel;
    logic                  unused_bits;

    assign addr_phase = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign wr_en      = dp_valid_reg & dp_write_reg;

    for (genvar gi = 0; gi < 5; gi++) begin : g_wr_dec
        assign wr_sel[gi] = wr_en && (dp_addr_reg == 3'(gi));
    end

    assign tick   = en_reg && (pcnt_reg == prescale_reg);
    assign expire = tick && (value_reg == '0);

    // Prescaler outcome if no bus write interferes this cycle.
    always_comb begin
        pcnt_run = pcnt_reg;
        if (en_reg) begin
            pcnt_run = tick ? '0 : pcnt_reg + 1'b1;
        end
    end

    always_comb begin
        en_next       = en_reg;
        irq_en_next   = irq_en_reg;
        oneshot_next  = oneshot_reg;
        load_next     = load_reg;
        value_next    = value_reg;
        prescale_next = prescale_reg;
        pcnt_next     = pcnt_run;
        timeout_next  = timeout_reg;

        if (tick) begin
            value_next = (value_reg != '0) ? value_reg - 32'd1
                                           : (oneshot_reg ? '0 : load_reg);
        end
        if (expire && oneshot_reg) begin
            en_next = 1'b0;
        end

        // Bus writes are applied last so they override the timer's own update.
        if (wr_sel[OFF_CTRL]) begin
            {oneshot_next, irq_en_next, en_next} = bus.HWDATA[2:0];
        end
        if (wr_sel[OFF_LOAD]) begin
            load_next  = bus.HWDATA;
            value_next = bus.HWDATA;
            pcnt_next  = '0;
        end
        if (wr_sel[OFF_PRESCALE]) begin
            prescale_next = bus.HWDATA[PRESCALE_W-1:0];
            if (pcnt_run > bus.HWDATA[PRESCALE_W-1:0]) begin
                pcnt_next = '0;
            end
        end

        if (expire) begin
            timeout_next = 1'b1;
        end else if (wr_sel[OFF_STATUS] && bus.HWDATA[0]) begin
            timeout_next = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_addr_reg  <= '0;
            en_reg       <= 1'b0;
            irq_en_reg   <= 1'b0;
            oneshot_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            load_reg     <= '0;
            value_reg    <= '0;
            prescale_reg <= '0;
            pcnt_reg     <= '0;
        end else begin
            dp_valid_reg <= addr_phase;
            if (addr_phase) begin
                dp_write_reg <= bus.HWRITE;
                dp_addr_reg  <= bus.HADDR[4:2];
            end
            en_reg       <= en_next;
            irq_en_reg   <= irq_en_next;
            oneshot_reg  <= oneshot_next;
            timeout_reg  <= timeout_next;
            load_reg     <= load_next;
            value_reg    <= value_next;
            prescale_reg <= prescale_next;
            pcnt_reg     <= pcnt_next;
        end
    end

    always_comb begin
        rdata = '0;
        if (dp_valid_reg && !dp_write_reg) begin
            case (dp_addr_reg)
                OFF_CTRL:     rdata = {29'd0, oneshot_reg, irq_en_reg, en_reg};
                OFF_LOAD:     rdata = load_reg;
                OFF_VALUE:    rdata = value_reg;
                OFF_PRESCALE: rdata = 32'(prescale_reg);
                OFF_STATUS:   rdata = {31'd0, timeout_reg};
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign irq           = timeout_reg & irq_en_reg;

    // Only word accesses exist and only HADDR[4:2] selects a register.
    assign unused_bits = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0], bus.HSIZE};
endmodule

// File: tb/tb_ahb_timer.sv
// Self-checking bench for ahb_timer: directed scenarios with literal
// expectations plus randomized bus traffic against a behavioural model.
module tb_ahb_timer;
    localparam int PW = 16;
    localparam logic [31:0] R_CTRL = 32'h00, R_LOAD = 32'h04, R_VALUE = 32'h08,
                            R_PRE  = 32'h0C, R_STAT = 32'h10;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b1;
    logic irq;

    ahb_timer_if bus();

    ahb_timer #(.PRESCALE_W(PW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus),
        .irq     (irq)
    );

    always #5 HCLK = ~HCLK;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state: register contents plus pending data phase.
    bit          m_en, m_irqen, m_oneshot, m_timeout, m_valid, m_write;
    logic [31:0] m_load, m_value;
    int          m_pre, m_cnt;
    logic [2:0]  m_addr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_en = 0; m_irqen = 0; m_oneshot = 0; m_timeout = 0;
        m_valid = 0; m_write = 0; m_addr = 0;
        m_load = 0; m_value = 0; m_pre = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] model_reg(input logic [2:0] a);
        case (a)
            3'd0:    return {29'd0, m_oneshot, m_irqen, m_en};
            3'd1:    return m_load;
            3'd2:    return m_value;
            3'd3:    return 32'(m_pre);
            3'd4:    return {31'd0, m_timeout};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the timer as described behaviourally.
    task automatic model_step();
        bit          tick, expire, en_n, to_n;
        int          cnt_n;
        logic [31:0] val_n;
        logic [31:0] wd;
        wd     = bus.HWDATA;
        tick   = m_en && (m_cnt == m_pre);
        expire = tick && (m_value == 0);
        cnt_n  = !m_en ? m_cnt : (tick ? 0 : m_cnt + 1);
        val_n  = m_value;
        if (tick) val_n = (m_value != 0) ? m_value - 1 : (m_oneshot ? 32'd0 : m_load);
        en_n   = m_en && !(expire && m_oneshot);
        to_n   = m_timeout || expire;
        if (m_valid && m_write) begin
            case (m_addr)
                3'd0: begin en_n = wd[0]; m_irqen = wd[1]; m_oneshot = wd[2]; end
                3'd1: begin m_load = wd; val_n = wd; cnt_n = 0; end
                3'd3: begin m_pre = int'(wd[PW-1:0]); if (cnt_n > m_pre) cnt_n = 0; end
                3'd4: if (wd[0] && !expire) to_n = 0;
                default: ;
            endcase
        end
        m_en = en_n; m_value = val_n; m_cnt = cnt_n; m_timeout = to_n;
        m_valid = bus.HSEL && bus.HREADY && bus.HTRANS[1];
        m_write = bus.HWRITE;
        m_addr  = bus.HADDR[4:2];
    endtask

    // One bus cycle: drive, clock, update model, compare all outputs.
    task automatic cyc_r(input bit sel, input logic [1:0] trans, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit rdy);
        bus.HSEL = sel; bus.HTRANS = trans; bus.HWRITE = wr; bus.HADDR = addr;
        bus.HWDATA = wdata; bus.HREADY = rdy; bus.HSIZE = 3'b010;
        @(posedge HCLK);
        if (!HRESETn) model_reset(); else model_step();
        @(negedge HCLK);
        check("hrdata", bus.HRDATA, (m_valid && !m_write) ? model_reg(m_addr) : 32'd0);
        check("irq", {31'd0, irq}, {31'd0, m_timeout && m_irqen});
        check("hready_hresp", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd2);
    endtask

    task automatic cyc(input bit sel, input logic [1:0] trans, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
        cyc_r(sel, trans, wr, addr, wdata, 1'b1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1, 2'b10, 1, a, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, d);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        cyc(1, 2'b10, 0, a, 32'd0);
        d = bus.HRDATA;
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 HRESETn = 1'b0;
        model_reset();
        #1;
        check({tag, "_hrdata_now"}, bus.HRDATA, 32'd0);
        check({tag, "_irq_now"}, {31'd0, irq}, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, 32'd0);
        HRESETn = 1'b1;
    endtask

    initial begin
        logic [31:0] d, a, wd;
        logic [2:0]  w;
        bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0; bus.HADDR = 0;
        bus.HWDATA = 0; bus.HREADY = 1; bus.HSIZE = 3'b010;
        model_reset();
        #1 HRESETn = 1'b0;
        repeat (3) cyc(0, 2'b00, 0, 32'd0, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_hrdata", bus.HRDATA, 32'd0);
        HRESETn = 1'b1;
        for (int r = 0; r < 5; r++) begin
            rd(32'(r * 4), d);
            check("rst_reg", d, 32'd0);
        end

        // Periodic, PRESCALE=0: VALUE 3,2,1,0 then timeout with reload.
        wr(R_PRE, 0); wr(R_LOAD, 3);
        cyc(1, 2'b10, 1, R_CTRL, 32'd0);
        cyc(1, 2'b10, 0, R_VALUE, 32'd3);
        check("per_v3", bus.HRDATA, 32'd3);
        for (int k = 2; k >= 0; k--) begin
            cyc(1, 2'b10, 0, R_VALUE, 32'd0);
            check("per_count", bus.HRDATA, 32'(k));
            check("per_irq_low", {31'd0, irq}, 32'd0);
        end
        cyc(1, 2'b10, 0, R_VALUE, 32'd0);
        check("per_reload", bus.HRDATA, 32'd3);
        check("per_irq_high", {31'd0, irq}, 32'd1);
        rd(R_STAT, d);
        check("per_status", d, 32'd1);

        // One-shot, PRESCALE=4, LOAD=1.
        wr(R_CTRL, 0); wr(R_STAT, 1);
        wr(R_PRE, 4); wr(R_LOAD, 1);
        cyc(1, 2'b10, 1, R_CTRL, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, 32'd5);
        for (int k = 1; k <= 10; k++) begin
            rd((k < 10) ? R_VALUE : R_STAT, d);
            if (k < 5)       check("os_value_hi", d, 32'd1);
            else if (k < 10) check("os_value_lo", d, 32'd0);
            else             check("os_timeout", d, 32'd1);
        end
        rd(R_CTRL, d);
        check("os_en_clear", d, 32'd4);
        repeat (6) cyc(0, 2'b00, 0, 32'd0, 32'd0);
        rd(R_VALUE, d);
        check("os_value_hold", d, 32'd0);

        // STATUS clear racing a hardware timeout: set wins.
        wr(R_CTRL, 0); wr(R_STAT, 1); wr(R_PRE, 0); wr(R_LOAD, 3);
        cyc(1, 2'b10, 1, R_CTRL, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, 32'd3);
        cyc(0, 2'b00, 0, 32'd0, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, 32'd0);
        cyc(1, 2'b10, 1, R_STAT, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, 32'd1);
        check("w1c_race_irq", {31'd0, irq}, 32'd1);
        cyc(1, 2'b10, 1, R_CTRL, 32'd0);
        cyc(1, 2'b10, 1, R_STAT, 32'd2);
        check("w1c_before_irq", {31'd0, irq}, 32'd1);
        cyc(0, 2'b00, 0, 32'd0, 32'd1);
        check("w1c_clear_irq", {31'd0, irq}, 32'd0);
        rd(R_STAT, d);
        check("w1c_status", d, 32'd0);

        // LOAD write coinciding with a tick (PRESCALE=3).
        wr(R_PRE, 3); wr(R_LOAD, 5);
        cyc(1, 2'b10, 1, R_CTRL, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, 32'd1);
        cyc(0, 2'b00, 0, 32'd0, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, 32'd0);
        cyc(1, 2'b10, 1, R_LOAD, 32'd0);
        cyc(1, 2'b10, 0, R_VALUE, 32'h100);
        check("ldtick_value", bus.HRDATA, 32'h100);
        for (int k = 0; k < 3; k++) begin
            rd(R_VALUE, d);
            check("ldtick_hold", d, 32'h100);
        end
        rd(R_VALUE, d);
        check("ldtick_next", d, 32'hFF);

        // Unmapped, idle and ignored accesses; back-to-back write/read.
        wr(R_CTRL, 0);
        rd(32'h14, d);
        check("unmapped_rd", d, 32'd0);
        cyc(1, 2'b00, 0, R_VALUE, 32'd0);
        check("idle_rd", bus.HRDATA, 32'd0);
        cyc(1, 2'b00, 1, R_LOAD, 32'd0);
        cyc(0, 2'b00, 0, 32'd0, 32'hDEAD);
        rd(R_LOAD, d);
        check("idle_wr_ignored", d, 32'h100);
        wr(R_VALUE, 77); wr(32'h14, 32'hFFFF_FFFF);
        rd(R_VALUE, d);
        check("value_ro", d, 32'hFF);
        cyc(1, 2'b10, 1, R_LOAD, 32'd0);
        cyc(1, 2'b10, 0, R_LOAD, 32'h1234);
        check("b2b_load", bus.HRDATA, 32'h1234);

        // Asynchronous reset mid-count with interrupt pending.
        wr(R_LOAD, 2); wr(R_CTRL, 3);
        repeat (14) cyc(0, 2'b00, 0, 32'd0, 32'd0);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        rd(R_LOAD, d);
        check("pre_rst_load", d, 32'd2);
        async_reset_pulse("arst");
        for (int r = 0; r < 5; r++) begin
            rd(32'(r * 4), d);
            check("arst_reg", d, 32'd0);
        end
        repeat (4) cyc(0, 2'b00, 0, 32'd0, 32'd0);
        check("arst_no_irq", {31'd0, irq}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            w  = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_FFE3) | {27'd0, w, 2'b00};
            wd = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 9));
            cyc_r($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, wd, $urandom_range(0, 7) != 0);
            if (i == 400) async_reset_pulse("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ahb_timer.md
AHB_TIMER -- requirements
Module: ahb_timer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, the width of the prescaler register and counter.
REQ-002 SHALL have port HCLK  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port HRESETn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port HSEL  in  1  slave select from the decoder.
REQ-005 SHALL have port HADDR  in  32  byte address; only bits [4:2] are decoded.
REQ-006 SHALL have port HTRANS  in  2  transfer type; NONSEQ and SEQ are active (HTRANS[1]=1).
REQ-007 SHALL have port HWRITE  in  1  1=write, 0=read.
REQ-008 SHALL have port HSIZE  in  3  transfer size; word access is the only supported size.
REQ-009 SHALL have port HWDATA  in  32  write data, valid in the data phase.
REQ-010 SHALL have port HREADY  in  1  bus-wide ready.
REQ-011 SHALL have port HREADYOUT  out  1  slave ready; constant 1.
REQ-012 SHALL have port HRESP  out  1  response; constant 0 (OKAY).
REQ-013 SHALL have port HRDATA  out  32  read data, valid in the data phase.
REQ-014 SHALL have port irq  out  1  level interrupt.

Function
REQ-015 SHALL capture the address phase (HADDR[4:2], HWRITE, valid) only when HSEL & HREADY & HTRANS[1] is true.
REQ-016 SHALL perform the register write in the following cycle, the data phase, using HWDATA; accesses have zero wait states.
REQ-017 SHALL drive HRDATA combinationally from the captured address during a read data phase.
REQ-018 SHALL implement the following register map:
- 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 ONESHOT.
- 0x04 LOAD.
- 0x08 VALUE, read-only.
- 0x0C PRESCALE, [PRESCALE_W-1:0].
- 0x10 STATUS: bit0 TIMEOUT, write-1-to-clear.
REQ-019 SHALL return 0 on reads of unmapped offsets and of unused bits, and SHALL ignore writes to unmapped offsets and to VALUE.
REQ-020 SHALL, while EN=1, increment the prescaler counter each cycle and generate a tick when the counter equals PRESCALE, returning the counter to 0 on the tick; PRESCALE=0 SHALL give a tick every cycle.
REQ-021 SHALL hold the prescaler counter and VALUE while EN=0.
REQ-022 SHALL, on a tick with VALUE!=0, decrement VALUE by 1.
REQ-023 SHALL, on a tick with VALUE==0, set TIMEOUT and then:
- periodic mode (ONESHOT=0): reload VALUE from LOAD;
- one-shot mode (ONESHOT=1): clear EN and hold VALUE at 0.
REQ-024 SHALL, on a write to LOAD, also load VALUE with the written value and clear the prescaler counter; if a tick occurs in the same cycle, the write SHALL take priority.
REQ-025 SHALL, on a write of 1 to STATUS bit0 in the same cycle as a hardware TIMEOUT set, leave TIMEOUT set (set wins).
REQ-026 SHALL, on a CTRL write in the same cycle as a one-shot auto-clear of EN, take EN from the written value.
REQ-027 SHALL drive irq = TIMEOUT & IRQ_EN as a registered-state combination, with no additional delay.
REQ-028 SHALL wrap no counter silently: VALUE never decrements below 0, and the prescaler never exceeds PRESCALE (a PRESCALE write below the current count SHALL clear the prescaler counter).

Reset
REQ-029 SHALL, while HRESETn=0, asynchronously clear CTRL, LOAD, VALUE, PRESCALE, STATUS, the prescaler counter and the captured address phase, giving irq=0, HRDATA=0, HREADYOUT=1 and HRESP=0.
REQ-030 SHALL, on reset asserted mid-count, restart from reset values with no tick or interrupt pending after release.

Verification
REQ-031 Bench SHALL cover: write PRESCALE=0, LOAD=3, CTRL=0x3 -> VALUE reads 3,2,1,0 on consecutive cycles; TIMEOUT=1 and irq=1 on the 4th tick; VALUE reloads to 3.
REQ-032 Bench SHALL cover: PRESCALE=4, LOAD=1, CTRL=0x5 -> VALUE decrements once per 5 cycles; TIMEOUT set after 10 cycles; EN reads 0; VALUE holds 0.
REQ-033 Bench SHALL cover: a STATUS write of 0x1 in the same cycle as a hardware timeout -> TIMEOUT remains 1; a later write of 0x1 with no tick clears it and irq drops in the same cycle.
REQ-034 Bench SHALL cover: a LOAD=0x100 write in the same cycle as a tick -> VALUE=0x100 and the prescaler counter is 0.
REQ-035 Bench SHALL cover: a read of 0x14 and of HADDR with HTRANS=IDLE -> HRDATA=0 and no register changes; back-to-back write then read of LOAD returns the new value.
REQ-036 Bench SHALL cover: HRESETn pulsed low asynchronously mid-count -> all registers read 0 and irq=0 immediately, without waiting for a clock edge.
